fetch_queue: RTL and testbench

Instruction fetch front-end with a small prefetch queue, feeding decode in the pipelined core. It sequences the PC, issues reads to the registered instruction memory, and buffers returned instructions with their PCs. It hands them to decode over a valid/ready handshake. A redirect from execute (taken branch or jump) flushes everything in flight and restarts fetch at the target.

---
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: PC sequencer, instruction memory read issue and
// prefetch queue of {pc, insn} entries handed to decode.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_addr_o         read address (current fetch PC)
//   imem_read_en_o      read request this cycle
//   imem_data_i         read data, valid the cycle after a request
//   redirect_i          execute redirect strobe (flushes everything)
//   redirect_pc_i       redirect target
//   valid_o / ready_i   decode handshake on the queue head
//   pc_o / insn_o       head entry
//   count_o             queue occupancy
//
// Build option: FETCH_QUEUE_BYPASS_EN lets the returning read drive
// the head directly when the queue is empty (1-cycle latency).
module fetch_queue #(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h01000000),
  parameter int                DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [AWIDTH-1:0]       imem_addr_o,
  output logic                    imem_read_en_o,
  input  logic [DWIDTH-1:0]       imem_data_i,
  input  logic                    redirect_i,
  input  logic [AWIDTH-1:0]       redirect_pc_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [AWIDTH-1:0]       pc_o,
  output logic [DWIDTH-1:0]       insn_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  entry_t            q_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] pending_pc;
  logic              pending;

  logic              issue;
  logic              push;
  logic              pop;
  logic              head_byp;
  logic [CW-1:0]     occ;
  entry_t            ret;
  entry_t            head;

  // Target word alignment drops the low bits.
  logic [1:0]        unused_lsb;
  assign unused_lsb = redirect_pc_i[1:0];

  assign ret = {pending_pc, imem_data_i};

  // Credit check counts the outstanding read but ignores a
  // same-cycle pop, so a returning read always finds a free slot.
  assign occ   = count + CW'(pending);
  assign issue = !rst && !redirect_i && (occ < FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign head_byp = (count == '0) && pending && !redirect_i;
`else
  assign head_byp = 1'b0;
`endif

  assign valid_o = (count != '0) || head_byp;
  assign head    = head_byp ? ret : q_mem[rd_ptr];
  assign pc_o    = head.pc;
  assign insn_o  = head.insn;

  // A bypassed entry taken by decode never enters the queue.
  assign pop  = (count != '0) && ready_i && !redirect_i;
  assign push = pending && !redirect_i && !(head_byp && ready_i);

  assign imem_addr_o    = fetch_pc;
  assign imem_read_en_o = issue;
  assign count_o        = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= BASEADDR;
      pending_pc <= BASEADDR;
      pending    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + AWIDTH'(4);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) q_mem[wr_ptr] <= ret;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, directed corner sequences and a
// randomized run against a queue-level reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] B = 32'h01000000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_data_i = '0;
  logic [31:0] imem_addr_o;
  logic        imem_read_en_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [2:0]  count_o;

  int checks = 0;
  int failures = 0;
  bit const_mem = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(
    .AWIDTH(32), .DWIDTH(32), .BASEADDR(B), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr_o(imem_addr_o),
    .imem_read_en_o(imem_read_en_o),
    .imem_data_i(imem_data_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .insn_o(insn_o),
    .count_o(count_o)
  );

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return const_mem ? 32'h00000013 : ~a;
  endfunction

  // Registered instruction memory; garbage when not read.
  always @(posedge clk)
    imem_data_i <= imem_read_en_o ? mem_word(imem_addr_o)
                                  : $urandom();

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched entries plus one pending read.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc = B;
  logic [31:0] m_ppc = B;
  bit          m_pend = 1'b0;

  function automatic bit m_byp();
    return BYP && mq.size() == 0 && m_pend && !redirect_i;
  endfunction

  task automatic model_check(string tag);
    bit          ev;
    bit          eren;
    logic [31:0] epc;
    logic [31:0] ei;
    eren = !rst && !redirect_i &&
           (mq.size() + int'(m_pend) < DEPTH);
    ev = (mq.size() != 0) || m_byp();
    if (m_byp()) begin
      epc = m_ppc;
      ei  = mem_word(m_ppc);
    end else if (mq.size() != 0) begin
      epc = mq[0].pc;
      ei  = mq[0].insn;
    end else begin
      epc = '0;
      ei  = '0;
    end
    chk({tag, ".ren"}, 32'(imem_read_en_o), 32'(eren));
    chk({tag, ".addr"}, imem_addr_o, m_fpc);
    chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
    chk({tag, ".count"}, 32'(count_o), 32'(mq.size()));
    if (ev) begin
      chk({tag, ".pc"}, pc_o, epc);
      chk({tag, ".insn"}, insn_o, ei);
    end
  endtask

  task automatic model_step();
    int n;
    bit byp;
    bit iss;
    n = mq.size();
    byp = m_byp();
    if (rst) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc = B;
      m_ppc = B;
    end else if (redirect_i) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      iss = (n + int'(m_pend)) < DEPTH;
      if (ready_i && n != 0) void'(mq.pop_front());
      if (m_pend && !(byp && ready_i))
        mq.push_back('{m_ppc, mem_word(m_ppc)});
      if (iss) begin
        m_ppc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
      m_pend = iss;
    end
  endtask

  task automatic drive(bit r, bit rd, logic [31:0] rpc, bit rdy);
    rst = r;
    redirect_i = rd;
    redirect_pc_i = rpc;
    ready_i = rdy;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    tick();
  endtask

  typedef struct {
    bit          r;
    bit          rd;
    logic [31:0] rpc;
    bit          rdy;
    bit          ren;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
    int          cnt;
  } vec_t;

  initial begin
    bit found;
    int phase_pct;
    bit r, rd, rdy;
    logic [31:0] rpc;
`ifndef FETCH_QUEUE_BYPASS_EN
    vec_t tbl[18];
    tbl[0]  = '{1, 0, 0, 1,        0, B,       0, 0,       0};
    tbl[1]  = '{0, 0, 0, 1,        1, B,       0, 0,       0};
    tbl[2]  = '{0, 0, 0, 1,        1, B+4,     0, 0,       0};
    tbl[3]  = '{0, 0, 0, 1,        1, B+8,     1, B,       1};
    tbl[4]  = '{0, 0, 0, 1,        1, B+'hC,   1, B+4,     1};
    tbl[5]  = '{0, 0, 0, 0,        1, B+'h10,  1, B+8,     1};
    tbl[6]  = '{0, 0, 0, 0,        1, B+'h14,  1, B+8,     2};
    tbl[7]  = '{0, 0, 0, 0,        0, B+'h18,  1, B+8,     3};
    tbl[8]  = '{0, 0, 0, 0,        0, B+'h18,  1, B+8,     4};
    tbl[9]  = '{0, 0, 0, 1,        0, B+'h18,  1, B+8,     4};
    tbl[10] = '{0, 0, 0, 0,        1, B+'h18,  1, B+'hC,   3};
    tbl[11] = '{0, 0, 0, 0,        0, B+'h1C,  1, B+'hC,   3};
    tbl[12] = '{0, 1, B+'h102, 1,  0, B+'h1C,  1, B+'hC,   4};
    tbl[13] = '{0, 0, 0, 1,        1, B+'h100, 0, 0,       0};
    tbl[14] = '{0, 0, 0, 1,        1, B+'h104, 0, 0,       0};
    tbl[15] = '{0, 0, 0, 1,        1, B+'h108, 1, B+'h100, 1};
    tbl[16] = '{1, 0, 0, 1,        0, B+'h10C, 1, B+'h104, 1};
    tbl[17] = '{0, 0, 0, 1,        1, B,       0, 0,       0};
`endif

    const_mem = 1'b0;
    do_reset();

`ifndef FETCH_QUEUE_BYPASS_EN
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].r, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d.ren", i), 32'(imem_read_en_o),
          32'(tbl[i].ren));
      chk($sformatf("tbl%0d.addr", i), imem_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d.valid", i), 32'(valid_o),
          32'(tbl[i].v));
      chk($sformatf("tbl%0d.count", i), 32'(count_o),
          32'(tbl[i].cnt));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d.pc", i), pc_o, tbl[i].pc);
        chk($sformatf("tbl%0d.insn", i), insn_o, ~tbl[i].pc);
      end
      tick();
    end
`endif

    // Streaming from reset with a constant-NOP memory.
    const_mem = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 1);
      chk($sformatf("strm%0d.valid", k), 32'(valid_o),
          32'(k >= LAT));
      if (k >= LAT) begin
        chk($sformatf("strm%0d.pc", k), pc_o,
            B + 32'(4 * (k - LAT)));
        chk($sformatf("strm%0d.insn", k), insn_o, 32'h13);
      end
      tick();
    end

    // Redirect with three entries queued and one read pending.
    const_mem = 1'b0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      drive(0, 0, 0, 0);
      if (count_o == 3'd3) found = 1'b1;
      else tick();
    end
    chk("fill3.count", 32'(count_o), 32'd3);
    chk("fill3.ren", 32'(imem_read_en_o), 32'd0);
    drive(0, 1, B + 32'h102, 0);
    chk("redir.ren", 32'(imem_read_en_o), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1);
      if (k == 0) begin
        chk("redir1.count", 32'(count_o), 32'd0);
        chk("redir1.ren", 32'(imem_read_en_o), 32'd1);
        chk("redir1.addr", imem_addr_o, B + 32'h100);
      end
      chk($sformatf("redir%0d.valid", k + 1), 32'(valid_o),
          32'(k >= LAT));
      if (k >= LAT)
        chk($sformatf("redir%0d.pc", k + 1), pc_o,
            B + 32'h100 + 32'(4 * (k - LAT)));
      tick();
    end

    // Reset pulse mid-stream with two entries queued.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      drive(0, 0, 0, 0);
      if (count_o == 3'd2) found = 1'b1;
      else tick();
    end
    chk("fill2.count", 32'(count_o), 32'd2);
    drive(1, 0, 0, 1);
    tick();
    drive(0, 0, 0, 1);
    chk("rstmid.count", 32'(count_o), 32'd0);
    chk("rstmid.valid", 32'(valid_o), 32'd0);
    chk("rstmid.ren", 32'(imem_read_en_o), 32'd1);
    chk("rstmid.addr", imem_addr_o, B);
    tick();

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      phase_pct = ((c / 40) % 2 == 0) ? 85 : 20;
      r   = ($urandom_range(0, 99) < 2);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = $urandom();
      rdy = ($urandom_range(0, 99) < phase_pct);
      drive(r, rd, rpc, rdy);
      model_check($sformatf("rnd%0d", c));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
